// File: rtl/plic_apb_arbiter_if.sv
// Bundle of the requester-side and PLIC-side APB signals around plic_apb_arbiter.
// The master modport is the arbiter's view; slave is the environment (requesters plus PLIC).
interface plic_apb_arbiter_if #(
  parameter int NMST = 2
);
  logic [NMST-1:0]      m_psel;
  logic [NMST-1:0]      m_penable;
  logic [NMST-1:0]      m_pwrite;
  logic [NMST*32-1:0]   m_paddr;
  logic [NMST*32-1:0]   m_pwdata;
  logic [NMST-1:0]      m_pready;
  logic [31:0]          m_prdata;
  logic                 m_pslverr;

  logic                 s_psel;
  logic                 s_penable;
  logic                 s_pwrite;
  logic [31:0]          s_paddr;
  logic [31:0]          s_pwdata;
  logic [31:0]          s_prdata;
  logic                 s_pready;
  logic                 s_pslverr;

  modport master (
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    output m_pready, m_prdata, m_pslverr,
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    input  s_prdata, s_pready, s_pslverr
  );

  modport slave (
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    input  m_pready, m_prdata, m_pslverr,
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    output s_prdata, s_pready, s_pslverr
  );
endinterface

// File: rtl/plic_apb_arbiter.sv
// Round-robin arbiter sharing one PLIC APB slave port between NMST requesters,
// with a per-access timeout that forces an error response if the PLIC hangs.
module plic_apb_arbiter #(
  parameter int NMST    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn,
  plic_apb_arbiter_if.master  bus,
  output logic [NMST-1:0]     grant,
  output logic                busy
);

  localparam int IW = (NMST > 1) ? $clog2(NMST) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit HAS_TMO = (TIMEOUT != 0);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic          found;
  logic [IW-1:0] winner;
  logic          sel_write;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;

  // Transactions are decoded from m_psel alone, so m_penable is deliberately unused.
  logic unused_penable;
  assign unused_penable = ^bus.m_penable;

  // Search order starts just after the last winner, giving strict rotation.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 1; k <= NMST; k++) begin
      for (int j = 0; j < NMST; j++) begin
        if (!found && (j == (int'(ptr) + k) % NMST) && bus.m_psel[j]) begin
          found     = 1'b1;
          winner    = IW'(j);
          sel_write = bus.m_pwrite[j];
          sel_addr  = bus.m_paddr[32*j +: 32];
          sel_wdata = bus.m_pwdata[32*j +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      ptr           <= IW'(NMST - 1);
      cnt           <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      bus.s_psel    <= 1'b0;
      bus.s_penable <= 1'b0;
      bus.s_pwrite  <= 1'b0;
      bus.s_paddr   <= '0;
      bus.s_pwdata  <= '0;
      bus.m_pready  <= '0;
      bus.m_prdata  <= '0;
      bus.m_pslverr <= 1'b0;
    end else begin
      bus.m_pready <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            ptr           <= winner;
            grant         <= NMST'(1) << winner;
            busy          <= 1'b1;
            bus.s_pwrite  <= sel_write;
            bus.s_paddr   <= sel_addr;
            bus.s_pwdata  <= sel_wdata;
            bus.s_psel    <= 1'b1;
            bus.s_penable <= 1'b0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          bus.s_penable <= 1'b1;
          cnt           <= '0;
          state         <= ACCESS;
        end
        ACCESS: begin
          if (bus.s_pready) begin
            bus.m_prdata    <= bus.s_prdata;
            bus.m_pslverr   <= bus.s_pslverr;
            bus.m_pready[ptr] <= 1'b1;
            bus.s_psel      <= 1'b0;
            bus.s_penable   <= 1'b0;
            state           <= DONE;
          end else if (HAS_TMO && (cnt == TMO_LAST)) begin
            bus.m_prdata    <= '0;
            bus.m_pslverr   <= 1'b1;
            bus.m_pready[ptr] <= 1'b1;
            bus.s_psel      <= 1'b0;
            bus.s_penable   <= 1'b0;
            state           <= DONE;
          end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plic_apb_arbiter.sv
// Randomized bench for plic_apb_arbiter: requesters and a PLIC stand-in driven
// with $urandom, every cycle compared against a transaction-timing reference model.
module tb_plic_apb_arbiter;

  localparam int NMST    = 3;
  localparam int TIMEOUT = 4;
  localparam int NCYCLES = 3000;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NMST-1:0] grant;
  logic            busy;

  int tests  = 0;
  int failed = 0;

  plic_apb_arbiter_if #(.NMST(NMST)) bus ();

  plic_apb_arbiter #(.NMST(NMST), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  bit          pend   [NMST];
  logic        rwrite [NMST];
  logic [31:0] raddr  [NMST];
  logic [31:0] rwdata [NMST];

  // A transaction granted at age 1 spends one SETUP cycle, mn ACCESS cycles, then one DONE cycle.
  int          mptr;
  bit          mbusy;
  int          mage;
  int          mn;
  int          mwaits;
  int          mwin;
  logic        mwrite;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] exp_prdata;
  logic        exp_pslverr;
  bit          first_txn;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbusy       = 1'b0;
    mage        = 0;
    mptr        = NMST - 1;
    exp_prdata  = '0;
    exp_pslverr = 1'b0;
    for (int i = 0; i < NMST; i++) pend[i] = 1'b0;
  endtask

  task automatic new_request(input int i);
    pend[i]   = 1'b1;
    rwrite[i] = 1'($urandom_range(0, 1));
    raddr[i]  = $urandom;
    rwdata[i] = $urandom;
  endtask

  task automatic check_cycle();
    logic [NMST-1:0] exp_grant;
    logic [NMST-1:0] exp_ready;
    logic            e_psel;
    logic            e_pen;
    exp_grant = '0;
    exp_ready = '0;
    e_psel    = 1'b0;
    e_pen     = 1'b0;
    if (mbusy) begin
      exp_grant = NMST'(1) << mwin;
      if (mage == 1) begin
        e_psel = 1'b1;
      end else if (mage <= 1 + mn) begin
        e_psel = 1'b1;
        e_pen  = 1'b1;
      end else begin
        exp_ready = exp_grant;
      end
    end
    check_output("s_psel",    64'(bus.s_psel),    64'(e_psel));
    check_output("s_penable", 64'(bus.s_penable), 64'(e_pen));
    check_output("grant",     64'(grant),         64'(exp_grant));
    check_output("busy",      64'(busy),          64'(mbusy));
    check_output("m_pready",  64'(bus.m_pready),  64'(exp_ready));
    check_output("m_prdata",  64'(bus.m_prdata),  64'(exp_prdata));
    check_output("m_pslverr", 64'(bus.m_pslverr), 64'(exp_pslverr));
    if (mbusy && mage <= 1 + mn) begin
      check_output("s_paddr",  64'(bus.s_paddr),  64'(maddr));
      check_output("s_pwdata", 64'(bus.s_pwdata), 64'(mwdata));
      check_output("s_pwrite", 64'(bus.s_pwrite), 64'(mwrite));
    end
  endtask

  task automatic apply_stimulus();
    bit done_now;
    bit ready;
    bit hit;
    int w;
    done_now = mbusy && (mage == 2 + mn);

    // Owners may re-request right after completion or, rarely, drop psel mid-transfer.
    for (int i = 0; i < NMST; i++) begin
      if (done_now && i == mwin && pend[i]) begin
        if ($urandom_range(0, 1) == 1) new_request(i);
        else pend[i] = 1'b0;
      end else if (mbusy && !done_now && i == mwin && pend[i] && $urandom_range(0, 31) == 0) begin
        pend[i] = 1'b0;
      end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
        new_request(i);
      end
    end
    for (int i = 0; i < NMST; i++) begin
      bus.m_psel[i]            = pend[i];
      bus.m_pwrite[i]          = rwrite[i];
      bus.m_paddr[32*i +: 32]  = raddr[i];
      bus.m_pwdata[32*i +: 32] = rwdata[i];
      bus.m_penable[i]         = 1'($urandom_range(0, 1));
    end

    // Outside ACCESS the PLIC lines carry noise that the arbiter must ignore.
    if (mbusy && mage >= 2 && mage <= 1 + mn) begin
      ready         = (mwaits < TIMEOUT) && (mage == 1 + mn);
      bus.s_pready  = ready;
      bus.s_prdata  = ready ? rsp_data : $urandom;
      bus.s_pslverr = ready ? rsp_err : 1'($urandom_range(0, 1));
    end else begin
      bus.s_pready  = 1'($urandom_range(0, 1));
      bus.s_prdata  = $urandom;
      bus.s_pslverr = 1'($urandom_range(0, 1));
    end

    if (mbusy) begin
      if (done_now) begin
        mbusy = 1'b0;
      end else begin
        if (mage == 1 + mn) begin
          exp_prdata  = rsp_data;
          exp_pslverr = rsp_err;
        end
        mage++;
      end
    end else begin
      hit = 1'b0;
      w   = 0;
      for (int k = 1; k <= NMST; k++) begin
        if (!hit && pend[(mptr + k) % NMST]) begin
          hit = 1'b1;
          w   = (mptr + k) % NMST;
        end
      end
      if (hit) begin
        mbusy  = 1'b1;
        mage   = 1;
        mptr   = w;
        mwin   = w;
        mwrite = rwrite[w];
        maddr  = raddr[w];
        mwdata = rwdata[w];
        mwaits = first_txn ? 0 : $urandom_range(0, 5);
        if (mwaits < TIMEOUT) begin
          mn       = mwaits + 1;
          rsp_data = $urandom;
          rsp_err  = first_txn ? 1'b0 : ($urandom_range(0, 3) == 0);
        end else begin
          mn       = TIMEOUT;
          rsp_data = '0;
          rsp_err  = 1'b1;
        end
        first_txn = 1'b0;
      end
    end
  endtask

  initial begin
    int next_reset;
    rstn          = 1'b0;
    bus.m_psel    = '0;
    bus.m_penable = '0;
    bus.m_pwrite  = '0;
    bus.m_paddr   = '0;
    bus.m_pwdata  = '0;
    bus.s_prdata  = '0;
    bus.s_pready  = 1'b0;
    bus.s_pslverr = 1'b0;
    for (int i = 0; i < NMST; i++) begin
      rwrite[i] = 1'b0;
      raddr[i]  = '0;
      rwdata[i] = '0;
    end
    model_reset();
    first_txn = 1'b1;
    mn        = 1;
    mwin      = 0;

    repeat (3) @(negedge clk);
    check_cycle();
    rstn      = 1'b1;
    pend[0]   = 1'b1;
    rwrite[0] = 1'b1;
    raddr[0]  = 32'h0C00_0004;
    rwdata[0] = 32'd7;
    apply_stimulus();
    next_reset = 400;

    for (int c = 0; c < NCYCLES; c++) begin
      @(negedge clk);
      check_cycle();
      if (c >= next_reset && mbusy && mage >= 2 && mage <= 1 + mn) begin
        #2 rstn = 1'b0;
        #1;
        check_output("rst_s_psel",    64'(bus.s_psel),    64'(0));
        check_output("rst_s_penable", 64'(bus.s_penable), 64'(0));
        check_output("rst_grant",     64'(grant),         64'(0));
        check_output("rst_busy",      64'(busy),          64'(0));
        check_output("rst_m_pready",  64'(bus.m_pready),  64'(0));
        check_output("rst_m_prdata",  64'(bus.m_prdata),  64'(0));
        check_output("rst_m_pslverr", 64'(bus.m_pslverr), 64'(0));
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        check_cycle();
        next_reset = c + 700;
      end
      apply_stimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
